// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: diff = a - b - bin, processed LSB first,
//   one bit per clock.
//
//   Datapath:
//   - A single full-subtract cell feeds a borrow flip-flop.
//   - Two operand shift registers present one bit per clock to the cell.
//   - A result shift register reassembles the parallel difference.
//
//   Control: a three-state FSM (IDLE / SHIFT / DONE).
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only in IDLE
//   a      in   [WIDTH] minuend, captured on accepted start
//   b      in   [WIDTH] subtrahend, captured on accepted start
//   bin    in   initial borrow-in, captured on accepted start
//   busy   out  high in SHIFT and DONE
//   done   out  one-cycle completion pulse
//   diff   out  [WIDTH] result register
//   bout   out  final borrow-out
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // Full-subtract cell on the current LSBs and the running borrow.
  logic d_bit;
  logic nb;
  assign d_bit = ra_q[0] ^ rb_q[0] ^ br_q;
  assign nb    = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          diff_d  = '0;
          bout_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // New bit enters at the MSB. Written as a shift of the concatenation
        // so that WIDTH=1 needs no empty part-select.
        diff_d = WIDTH'({d_bit, diff_q} >> 1);
        ra_d   = ra_q >> 1;
        rb_d   = rb_q >> 1;
        br_d   = nb;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bout_d  = nb;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
